// File: rtl/ddf_pick_1p2f_ms_pkg.sv
// ============================================================================
// ddf_pkg : shared defaults, FSM state type and helpers for ddf_pick_1p2f_ms
// Rev 1.0
// ============================================================================
`default_nettype none

package ddf_pkg;

    localparam int DEF_FLUX      = 2;
    localparam int DEF_TAG_WIDTH = $clog2(DEF_FLUX);
    localparam int DEF_PICK_N    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONSUME = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Tag = top tag_w bits of a width-bit token (token passed zero-extended).
    function automatic logic [31:0] tag_of(input logic [31:0] tok, input int width, input int tag_w);
        return (tok >> (width - tag_w)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddf_pick_1p2f_ms_if.sv
// ============================================================================
// ddf_pick_1p2f_ms_if : tagged main/NDA input ports and tagged output port
// Rev 1.0
// ============================================================================
`default_nettype none

interface ddf_pick_1p2f_ms_if #(
    parameter int FLUX      = 2,
    parameter int WIDTH     = 9,
    parameter int WIDTH_NDA = 9
);
    logic                 in_port_write;
    logic [WIDTH-1:0]     in_port_datain;
    logic [FLUX-1:0]      in_port_full;
    logic                 in_port_write_nda;
    logic [WIDTH_NDA-1:0] in_port_datain_nda;
    logic [FLUX-1:0]      in_port_full_nda;
    logic                 out_port_write;
    logic [WIDTH-1:0]     out_port_dataout;
    logic                 out_port_full;

    modport master (
        output in_port_write, in_port_datain, in_port_write_nda, in_port_datain_nda, out_port_full,
        input  in_port_full, in_port_full_nda, out_port_write, out_port_dataout
    );

    modport slave (
        input  in_port_write, in_port_datain, in_port_write_nda, in_port_datain_nda, out_port_full,
        output in_port_full, in_port_full_nda, out_port_write, out_port_dataout
    );
endinterface

`default_nettype wire

// File: rtl/ddf_pick_1p2f_ms_tag_fifo.sv
// ============================================================================
// ddf_tag_fifo : show-ahead FIFO, drops pushes when full unless popped same cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module ddf_tag_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_full);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddf_pick_1p2f_ms.sv
// ============================================================================
// ddf_pick_1p2f_ms : multi-stream PICK actor, PICK_N main + 1 NDA -> NDA out
// Rev 1.0
// ============================================================================
`default_nettype none

module ddf_pick_1p2f_ms
    import ddf_pkg::*;
#(
    parameter int FLUX      = DEF_FLUX,
    parameter int TAG_WIDTH = $clog2(FLUX),
    parameter int WIDTH     = 9,
    parameter int WIDTH_NDA = 9,
    parameter int DEPTH     = 8,
    parameter int PICK_N    = DEF_PICK_N
) (
    input  logic              clk,
    input  logic              rst,
    ddf_pick_1p2f_ms_if.slave bus
);
    localparam int c_cw     = $clog2(DEPTH) + 1;
    localparam int c_nw     = $clog2(PICK_N + 1);
    localparam int c_pw     = WIDTH - TAG_WIDTH;
    localparam int c_pw_nda = WIDTH_NDA - TAG_WIDTH;
    localparam logic [c_nw-1:0] c_pick = PICK_N[c_nw-1:0];

    logic [FLUX-1:0]      w_main_push, w_main_pop, w_main_full, w_main_empty;
    logic [FLUX-1:0]      w_nda_push, w_nda_pop, w_nda_full, w_nda_empty;
    logic [WIDTH-1:0]     w_main_dout  [FLUX];
    logic [WIDTH_NDA-1:0] w_nda_dout   [FLUX];
    logic [c_cw-1:0]      w_main_count [FLUX];
    logic [c_cw-1:0]      w_nda_count  [FLUX];

    state_t               r_state, w_next_state;
    logic [c_nw-1:0]      r_cnt [FLUX];
    logic [TAG_WIDTH-1:0] r_rr;
    logic [TAG_WIDTH-1:0] w_sel;
    logic [WIDTH-1:0]     r_out_data;

    for (genvar f = 0; f < FLUX; f++) begin : g_flux
        assign w_main_push[f] = bus.in_port_write &&
            (TAG_WIDTH'(tag_of(32'(bus.in_port_datain), WIDTH, TAG_WIDTH)) == TAG_WIDTH'(f));
        assign w_nda_push[f]  = bus.in_port_write_nda &&
            (TAG_WIDTH'(tag_of(32'(bus.in_port_datain_nda), WIDTH_NDA, TAG_WIDTH)) == TAG_WIDTH'(f));

        ddf_tag_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_main (
            .clk(clk), .rst(rst), .push(w_main_push[f]), .pop(w_main_pop[f]),
            .din(bus.in_port_datain), .dout(w_main_dout[f]), .full(w_main_full[f]),
            .empty(w_main_empty[f]), .count(w_main_count[f])
        );

        ddf_tag_fifo #(.WIDTH(WIDTH_NDA), .DEPTH(DEPTH)) u_nda (
            .clk(clk), .rst(rst), .push(w_nda_push[f]), .pop(w_nda_pop[f]),
            .din(bus.in_port_datain_nda), .dout(w_nda_dout[f]), .full(w_nda_full[f]),
            .empty(w_nda_empty[f]), .count(w_nda_count[f])
        );
    end

    assign bus.in_port_full     = w_main_full;
    assign bus.in_port_full_nda = w_nda_full;

    // Main payloads are discarded by the actor; counts are only observability.
    logic w_unused;
    always_comb begin
        w_unused = 1'b0;
        for (int f = 0; f < FLUX; f++)
            w_unused = w_unused ^ (^w_main_dout[f]) ^ (^w_main_count[f]) ^
                       (^w_nda_count[f]) ^ (^w_nda_dout[f]);
    end

    always_comb begin
        logic                 emit_ok, cons_ok;
        logic [TAG_WIDTH-1:0] emit_sel, cons_sel, idx;
        w_next_state = IDLE;
        w_sel        = r_rr;
        w_main_pop   = '0;
        w_nda_pop    = '0;
        emit_ok      = 1'b0;
        cons_ok      = 1'b0;
        emit_sel     = '0;
        cons_sel     = '0;
        idx          = '0;
        // Both searches start at the round-robin pointer; emit wins over consume.
        for (int i = 0; i < FLUX; i++) begin
            idx = TAG_WIDTH'(rr_idx(int'(r_rr), i, FLUX));
            if (!emit_ok && r_cnt[idx] == c_pick && !w_nda_empty[idx] && !bus.out_port_full) begin
                emit_ok  = 1'b1;
                emit_sel = idx;
            end
            if (!cons_ok && r_cnt[idx] != c_pick && !w_main_empty[idx]) begin
                cons_ok  = 1'b1;
                cons_sel = idx;
            end
        end
        if (emit_ok) begin
            w_next_state        = EMIT;
            w_sel               = emit_sel;
            w_nda_pop[emit_sel] = 1'b1;
        end else if (cons_ok) begin
            w_next_state         = CONSUME;
            w_sel                = cons_sel;
            w_main_pop[cons_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr       <= '0;
            r_out_data <= '0;
            for (int f = 0; f < FLUX; f++) r_cnt[f] <= '0;
        end else begin
            if (w_next_state == EMIT) begin
                r_cnt[w_sel] <= '0;
                r_out_data   <= {w_sel, c_pw'(w_nda_dout[w_sel][c_pw_nda-1:0])};
            end else if (w_next_state == CONSUME) begin
                r_cnt[w_sel] <= r_cnt[w_sel] + c_nw'(1);
            end
            if (w_next_state != IDLE) r_rr <= TAG_WIDTH'(rr_idx(int'(w_sel), 1, FLUX));
        end
    end

    assign bus.out_port_write   = (r_state == EMIT);
    assign bus.out_port_dataout = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_ddf_pick_1p2f_ms.sv
// ============================================================================
// tb_ddf_pick_1p2f_ms : directed self-checking bench for ddf_pick_1p2f_ms
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddf_pick_1p2f_ms;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   viol  = 0;
    logic prev_full = 1'b0;

    logic [8:0] q0[$], q1[$], e0[$], e1[$];

    ddf_pick_1p2f_ms_if #(.FLUX(2), .WIDTH(9), .WIDTH_NDA(9)) bus ();

    ddf_pick_1p2f_ms #(
        .FLUX(2), .TAG_WIDTH(1), .WIDTH(9), .WIDTH_NDA(9), .DEPTH(8), .PICK_N(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Outputs sampled mid-cycle; a pulse needs out_port_full low on the deciding edge.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.out_port_write) begin
                if (prev_full) viol++;
                if (bus.out_port_dataout[8]) q1.push_back(bus.out_port_dataout);
                else                         q0.push_back(bus.out_port_dataout);
            end
        end
        prev_full = bus.out_port_full;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_q(input string name);
        check({name, "_n0"}, q0.size(), e0.size());
        check({name, "_n1"}, q1.size(), e1.size());
        for (int i = 0; i < e0.size() && i < q0.size(); i++)
            check($sformatf("%s_f0_%0d", name, i), q0[i], e0[i]);
        for (int i = 0; i < e1.size() && i < q1.size(); i++)
            check($sformatf("%s_f1_%0d", name, i), q1[i], e1[i]);
        q0.delete(); q1.delete(); e0.delete(); e1.delete();
    endtask

    task automatic wr(input bit nda, input logic [8:0] tok);
        if (nda) begin
            bus.in_port_write_nda  = 1'b1;
            bus.in_port_datain_nda = tok;
        end else begin
            bus.in_port_write  = 1'b1;
            bus.in_port_datain = tok;
        end
        @(posedge clk); #1;
        bus.in_port_write     = 1'b0;
        bus.in_port_write_nda = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_port_write      = 1'b0;
        bus.in_port_datain     = '0;
        bus.in_port_write_nda  = 1'b0;
        bus.in_port_datain_nda = '0;
        bus.out_port_full      = 1'b0;

        // Reset held with writes active
        @(posedge clk); #1;
        bus.in_port_write      = 1'b1;
        bus.in_port_datain     = 9'h012;
        bus.in_port_write_nda  = 1'b1;
        bus.in_port_datain_nda = 9'h033;
        repeat (3) begin
            @(negedge clk);
            check("rst_full",     bus.in_port_full,     0);
            check("rst_full_nda", bus.in_port_full_nda, 0);
            check("rst_wr",       bus.out_port_write,   0);
            check("rst_data",     bus.out_port_dataout, 0);
        end
        @(posedge clk); #1;
        bus.in_port_write     = 1'b0;
        bus.in_port_write_nda = 1'b0;
        rst = 1'b1;
        wait_cyc(2);

        // Basic: 3 mains must not fire (FIFOs empty after reset), 4th does
        for (int i = 0; i < 3; i++) wr(0, 9'h001);
        wr(1, 9'h004);
        wait_cyc(10);
        check("basic_hold", q0.size() + q1.size(), 0);
        wr(0, 9'h001);
        for (int i = 0; i < 4; i++) wr(0, 9'h101);
        wr(1, 9'h104);
        wait_cyc(12);
        e0.push_back(9'h004);
        e1.push_back(9'h104);
        cmp_q("basic");

        // Interleaved with back-pressure window
        for (int i = 0; i < 8; i++) begin
            wr(0, 9'h001);
            wr(0, 9'h101);
            if (i == 1 || i == 3) begin
                wr(1, 9'h004);
                wr(1, 9'h104);
            end
            if (i == 3) bus.out_port_full = 1'b1;
            if (i == 6) bus.out_port_full = 1'b0;
        end
        wait_cyc(30);
        e0.push_back(9'h004); e0.push_back(9'h004);
        e1.push_back(9'h104); e1.push_back(9'h104);
        cmp_q("ilv");

        // Payload independence
        wr(0, 9'h107); wr(0, 9'h109); wr(0, 9'h103); wr(0, 9'h1FA);
        wr(1, 9'h155);
        wait_cyc(10);
        e1.push_back(9'h155);
        cmp_q("payload");

        // Overflow of flux0 main FIFO while its count is saturated
        bus.out_port_full = 1'b1;
        for (int i = 0; i < 4; i++) wr(0, 9'h000);
        wr(1, 9'h0AA);
        wait_cyc(8);
        for (int i = 0; i < 10; i++) begin
            wr(0, 9'(i));
            if (i == 6) check("ovf_not_full_7", bus.in_port_full[0], 0);
            if (i == 7) check("ovf_full_8",     bus.in_port_full[0], 1);
        end
        check("ovf_full_end", bus.in_port_full, 2'b01);
        for (int i = 0; i < 4; i++) wr(0, 9'h1E0);
        wr(1, 9'h122);
        wait_cyc(8);
        check("ovf_bp_hold", q0.size() + q1.size(), 0);
        check("ovf_f1_free", bus.in_port_full[1], 0);
        bus.out_port_full = 1'b0;
        wait_cyc(20);
        wr(1, 9'h001); wait_cyc(10);
        wr(1, 9'h002); wait_cyc(10);
        wr(1, 9'h003); wait_cyc(10);
        e0.push_back(9'h0AA); e0.push_back(9'h001); e0.push_back(9'h002);
        e1.push_back(9'h122);
        cmp_q("ovf_a");
        wr(0, 9'h000); wr(0, 9'h000);
        wait_cyc(10);
        cmp_q("ovf_b");
        wr(0, 9'h000); wr(0, 9'h000);
        wait_cyc(10);
        e0.push_back(9'h003);
        cmp_q("ovf_c");

        // Starvation: flux1 lacks NDA while flux0 proceeds
        for (int i = 0; i < 4; i++) wr(0, 9'h177);
        for (int i = 0; i < 4; i++) wr(0, 9'h011);
        wr(1, 9'h011);
        wait_cyc(15);
        e0.push_back(9'h011);
        cmp_q("starve_a");
        wr(1, 9'h166);
        wait_cyc(10);
        e1.push_back(9'h166);
        cmp_q("starve_b");

        check("no_wr_while_full", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddf_pick_1p2f_ms.md
Name: ddf_pick_1p2f_ms

Overview:
- Multi-stream (MS) dynamic-dataflow wrapper around one PICK actor shared by FLUX=2 tagged streams ("fluxes").
- Two tagged input ports feed per-flux FIFOs:
  - main data port;
  - NDA (non-data-argument) port.
- For each flux, the actor consumes PICK_N main tokens plus one NDA token, then emits the NDA payload with the flux tag on one tagged output port that honours back-pressure.
- Sits between tagged-stream producers and a downstream FIFO.

Parameters:
- FLUX, 2: number of interleaved streams.
- TAG_WIDTH, $clog2(FLUX): tag bits, MSBs of every token.
- WIDTH, 9: main token width (tag + payload).
- WIDTH_NDA, 9: NDA token width (tag + payload).
- DEPTH, 8: entries per per-flux FIFO (power of 2).
- PICK_N, 4: main tokens consumed per firing.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_port_write  in  1  main token valid.
- in_port_datain  in  WIDTH  {tag, payload}.
- in_port_full  out  FLUX  bit f: main FIFO of flux f is full.
- in_port_write_nda  in  1  NDA token valid.
- in_port_datain_nda  in  WIDTH_NDA  {tag, payload}.
- in_port_full_nda  out  FLUX  bit f: NDA FIFO of flux f is full.
- out_port_write  out  1  output token valid, one-cycle pulse per token.
- out_port_dataout  out  WIDTH  {tag, picked payload}.
- out_port_full  in  1  downstream full; no write is issued while high.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is asynchronous, active-low.
  - While rst=0, all of the following are cleared:
    - FIFOs become empty;
    - in_port_full and in_port_full_nda become 0;
    - out_port_write=0 and out_port_dataout=0;
    - per-flux counters become 0;
    - round-robin pointer becomes 0;
    - FSM goes to IDLE.
  - Reset mid-operation discards all buffered and partial state.
- Input routing:
  - On each rising edge with in_port_write=1, the token goes to main FIFO[tag].
  - If that FIFO is full, the token is dropped with no side effect.
  - The NDA port works identically with its own FIFOs.
  - The full flags are combinational from the FIFO counts.
  - A token written at edge k is poppable from edge k+1.
  - A simultaneous push and pop on a full FIFO is allowed; the count is unchanged.
- Actor, per-flux state:
  - cnt[f] runs 0..PICK_N and counts main tokens consumed in the current firing.
- Actor FSM, one action per clock:
  - Emit action, evaluated first:
    - Flux f is ready when cnt[f]==PICK_N, NDA FIFO[f] is non-empty, and out_port_full=0.
    - For the ready flux f, pop NDA[f].
    - Next cycle: out_port_write=1 and out_port_dataout={f, nda_payload}.
    - Clear cnt[f].
  - Consume action, taken otherwise:
    - Pick the next flux in round-robin order from the pointer with a non-empty main FIFO and cnt<PICK_N.
    - Pop one token and increment cnt.
    - The main payload is discarded.
    - Advance the pointer past the chosen flux.
  - Emit ties between fluxes use the same round-robin pointer.
- Back-pressure:
  - While out_port_full=1, no emit occurs.
  - Consumption continues until cnt==PICK_N for each flux.
  - Inputs keep buffering until their FIFOs fill.
- Output: out_port_write is registered and never asserts for two tokens in the same cycle.
- Flux order: output tokens of one flux appear in NDA arrival order; fluxes may interleave.
- Latency: from the last required token being poppable to out_port_write is 1–2 cycles.

Decomposition:
- Package ddf_pkg holds:
  - tag extraction helper;
  - FLUX, TAG_WIDTH and PICK_N defaults;
  - FSM state enum (IDLE, CONSUME, EMIT).
- One sub-module: ddf_tag_fifo.
  - Parameterised WIDTH/DEPTH.
  - Ports: push, pop, dout, full, empty, count.
  - Instantiated FLUX times for main and FLUX times for NDA.

Test Plan:
- Reset: hold rst=0 for 3 cycles with writes active -> full flags 0, no out_port_write, FIFOs empty after release.
- Basic: flux0 gets 4 main {0,1} plus NDA {0,4}; flux1 likewise with {1,1}/{1,4} -> exactly two outputs, 0x004 and 0x104, one pulse each.
- Interleaved with back-pressure:
  - Stimulus: 8 main tokens per flux with payload 1, interleaved; 2 NDA tokens of payload 4 per flux; out_port_full=1 for ~6 cycles mid-stream.
  - Required: flux0 outputs 0x004, 0x004; flux1 outputs 0x104, 0x104.
  - Zero writes while full; no drops.
- Payload independence: main payloads 7, 9, 3, 250 with NDA {1,0x55} -> output 0x155.
- Overflow: write DEPTH+2 main tokens to flux0 while cnt is saturated and out_port_full=1 -> in_port_full[0]=1 after DEPTH tokens, extras dropped, flux1 unaffected.
- Starvation: flux1 has 4 main tokens and no NDA -> flux1 does not emit; flux0 progresses normally until flux1's NDA arrives, then flux1 emits 0x1xx.
